// File: rtl/keypad_scan_decoder.sv
// rtl/keypad_scan_decoder.sv - 4x4 keypad column scan, row debounce and key code strobe
//
// Purpose:
//   Drives active-low one-hot columns from an external 2-bit scan counter,
//   synchronises the asynchronous row inputs, debounces a press and its
//   release, and emits a key code with a single-cycle valid pulse. The
//   external counter is paced through stop_o: it only advances during the
//   single ADVANCE cycle that follows an idle dwell or a debounced release.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-low reset
//   scan_idx_i   in   [1:0] column index from the scan counter
//   row_i        in   [3:0] raw rows, asynchronous, active-low, pulled up
//   col_o        out  [3:0] column drive, active-low one-hot, registered
//   stop_o       out  1 = hold counter, 0 = advance one step
//   key_code_o   out  [3:0] code of the last accepted key
//   key_valid_o  out  one-cycle pulse when key_code_o updates
//
// Build option:
//   KEYPAD_HEX_MAP_EN  when defined, codes follow the hex keypad legend
//                      (1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D); otherwise
//                      the raw code row*4+col is reported.

module keypad_scan_decoder #(
    parameter int DWELL_CYCLES = 8,
    parameter int DB_CYCLES    = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] scan_idx_i,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic       stop_o,
    output logic [3:0] key_code_o,
    output logic       key_valid_o
);

    localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);
    localparam int DB_W    = $clog2(DB_CYCLES + 1);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DB_CYCLES - 1);

    localparam logic [2:0] ST_SCAN     = 3'd0;
    localparam logic [2:0] ST_ADVANCE  = 3'd1;
    localparam logic [2:0] ST_DEBOUNCE = 3'd2;
    localparam logic [2:0] ST_HELD     = 3'd3;
    localparam logic [2:0] ST_RELEASE  = 3'd4;

    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    logic [2:0]         state_q, state_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic [3:0]         col_q, col_d;
    logic [3:0]         sync1_q, sync1_d;
    logic [3:0]         row_s_q, row_s_d;
    logic [1:0]         col_idx_q, col_idx_d;
    logic [1:0]         row_idx_q, row_idx_d;
    logic [3:0]         row_ref_q, row_ref_d;
    logic [3:0]         key_code_q, key_code_d;
    logic               key_valid_q, key_valid_d;

    logic               key_seen;
    logic [1:0]         row_enc;
    logic               row_match;
    logic               rows_idle;

    // Map a (row, column) position to the reported key code.
    function automatic logic [3:0] key_code_of(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
`ifdef KEYPAD_HEX_MAP_EN
        case ({r, c})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            default: code = 4'hD;
        endcase
`else
        code = {r, c};
`endif
        return code;
    endfunction

    assign key_seen  = (row_s_q != ROWS_IDLE);
    assign row_match = (row_s_q == row_ref_q);
    assign rows_idle = (row_s_q == ROWS_IDLE);

    // Lowest-index low row wins when several rows are pulled down together.
    always_comb begin
        row_enc = 2'd0;
        if (!row_s_q[0]) begin
            row_enc = 2'd0;
        end else if (!row_s_q[1]) begin
            row_enc = 2'd1;
        end else if (!row_s_q[2]) begin
            row_enc = 2'd2;
        end else if (!row_s_q[3]) begin
            row_enc = 2'd3;
        end
    end

    always_comb begin
        state_d     = state_q;
        dwell_d     = dwell_q;
        db_cnt_d    = db_cnt_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        row_ref_d   = row_ref_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;

        // The column register always follows the counter; while this block
        // holds stop_o high the counter is frozen, so the drive is frozen too.
        col_d   = ~(4'b0001 << scan_idx_i);
        sync1_d = row_i;
        sync2_assign: begin
            row_s_d = sync1_q;
        end

        case (state_q)
            ST_SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (key_seen) begin
                        col_idx_d = scan_idx_i;
                        row_idx_d = row_enc;
                        row_ref_d = row_s_q;
                        db_cnt_d  = '0;
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        state_d = ST_ADVANCE;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end

            ST_ADVANCE: begin
                dwell_d = '0;
                state_d = ST_SCAN;
            end

            ST_DEBOUNCE: begin
                if (row_match) begin
                    if (db_cnt_q == DB_LAST) begin
                        db_cnt_d    = '0;
                        key_code_d  = key_code_of(row_idx_q, col_idx_q);
                        key_valid_d = 1'b1;
                        state_d     = ST_HELD;
                    end else begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end else begin
                    // A bounce re-runs the dwell on the same column; the
                    // counter was never released, so no column is skipped.
                    db_cnt_d = '0;
                    dwell_d  = '0;
                    state_d  = ST_SCAN;
                end
            end

            ST_HELD: begin
                if (rows_idle) begin
                    db_cnt_d = '0;
                    state_d  = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                if (rows_idle) begin
                    if (db_cnt_q == DB_LAST) begin
                        db_cnt_d = '0;
                        state_d  = ST_ADVANCE;
                    end else begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end else begin
                    db_cnt_d = '0;
                    state_d  = ST_HELD;
                end
            end

            default: begin
                dwell_d  = '0;
                db_cnt_d = '0;
                state_d  = ST_SCAN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_SCAN;
            dwell_q     <= '0;
            db_cnt_q    <= '0;
            col_q       <= 4'b1111;
            sync1_q     <= 4'b1111;
            row_s_q     <= 4'b1111;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            row_ref_q   <= 4'b1111;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            db_cnt_q    <= db_cnt_d;
            col_q       <= col_d;
            sync1_q     <= sync1_d;
            row_s_q     <= row_s_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            row_ref_q   <= row_ref_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign col_o       = col_q;
    assign stop_o      = (state_q != ST_ADVANCE);
    assign key_code_o  = key_code_q;
    assign key_valid_o = key_valid_q;

endmodule
